// File: rtl/bsg_sync_filter_edge_if.sv
// Bundle of the conditioner's data-side signals.
// The master side drives raw levels and hold; the slave side (the conditioner) returns
// filtered levels, edge pulses and the change summary.
interface bsg_sync_filter_edge_if #(
  parameter int width_p = 32
);

  logic [width_p-1:0] async_data_i;
  logic               hold_i;
  logic [width_p-1:0] data_o;
  logic [width_p-1:0] rise_o;
  logic [width_p-1:0] fall_o;
  logic               any_change_o;

  modport master (
    output async_data_i,
    output hold_i,
    input  data_o,
    input  rise_o,
    input  fall_o,
    input  any_change_o
  );

  modport slave (
    input  async_data_i,
    input  hold_i,
    output data_o,
    output rise_o,
    output fall_o,
    output any_change_o
  );

endinterface

// File: rtl/bsg_sync_filter_edge.sv
// Multi-channel input conditioner.
// Each channel passes through a sync_stages_p-deep synchronizer, then a stability filter
// that only accepts a new level after filter_cycles_p consecutive mismatching cycles.
// Accepted level changes produce registered one-cycle rise/fall pulses. Channels are
// fully independent; no cross-bit coherency is implied.
module bsg_sync_filter_edge #(
  parameter int width_p         = 32,
  parameter int sync_stages_p   = 2,
  parameter int filter_cycles_p = 3,
  parameter bit reset_val_p     = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bsg_sync_filter_edge_if.slave   bus
);

  localparam int cnt_width_lp = (filter_cycles_p > 1) ? $clog2(filter_cycles_p) : 1;
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(filter_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

  logic [width_p-1:0]      sync_r [sync_stages_p];
  logic [width_p-1:0]      synced;

  logic [cnt_width_lp-1:0] cnt_r  [width_p];
  logic [cnt_width_lp-1:0] cnt_n  [width_p];
  logic [width_p-1:0]      data_r;
  logic [width_p-1:0]      data_n;
  logic [width_p-1:0]      rise_r;
  logic [width_p-1:0]      rise_n;
  logic [width_p-1:0]      fall_r;
  logic [width_p-1:0]      fall_n;

  // Synchronizer shift chain; runs even while hold is asserted so it never goes stale.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < sync_stages_p; k++) begin
        sync_r[k] <= {width_p{reset_val_p}};
      end
    end else begin
      sync_r[0] <= bus.async_data_i;
      for (int k = 1; k < sync_stages_p; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign synced = sync_r[sync_stages_p-1];

  // Per-bit filter: count consecutive mismatch cycles, accept the new level on the last one.
  always_comb begin
    cnt_n  = cnt_r;
    data_n = data_r;
    rise_n = '0;
    fall_n = '0;
    if (!bus.hold_i) begin
      for (int i = 0; i < width_p; i++) begin
        if (synced[i] == data_r[i]) begin
          cnt_n[i] = '0;
        end else if (cnt_r[i] == cnt_max_lp) begin
          data_n[i] = synced[i];
          cnt_n[i]  = '0;
          rise_n[i] = synced[i];
          fall_n[i] = ~synced[i];
        end else begin
          cnt_n[i] = cnt_r[i] + cnt_one_lp;
        end
      end
    end
  end

  // Filter state and edge-pulse registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < width_p; i++) begin
        cnt_r[i] <= '0;
      end
      data_r <= {width_p{reset_val_p}};
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      cnt_r  <= cnt_n;
      data_r <= data_n;
      rise_r <= rise_n;
      fall_r <= fall_n;
    end
  end

  assign bus.data_o       = data_r;
  assign bus.rise_o       = rise_r;
  assign bus.fall_o       = fall_r;
  assign bus.any_change_o = |(rise_r | fall_r);

endmodule

// File: tb/tb_bsg_sync_filter_edge.sv
// Bench for bsg_sync_filter_edge: constant vector table, hand-built reset corner
// sequences, and randomized levels compared against a queue-based reference model.
module tb_bsg_sync_filter_edge;

  localparam int   width_lp     = 4;
  localparam int   stages_lp    = 2;
  localparam int   filter_lp    = 3;
  localparam logic reset_val_lp = 1'b0;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  logic clk_en  = 1'b0;

  int errors = 0;
  int checks = 0;

  bsg_sync_filter_edge_if #(.width_p(width_lp)) bus ();

  bsg_sync_filter_edge #(
    .width_p        (width_lp),
    .sync_stages_p  (stages_lp),
    .filter_cycles_p(filter_lp),
    .reset_val_p    (reset_val_lp)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  // Free-running clock once enabled, so the reset-without-clock check sees no edges.
  always #5 if (clk_en) clk_i = ~clk_i;

  // Reference model: history of captured inputs plus an unbounded mismatch run length per bit.
  logic [width_lp-1:0] hist_q[$];
  logic [width_lp-1:0] m_data;
  logic [width_lp-1:0] m_rise;
  logic [width_lp-1:0] m_fall;
  int                  run_len[width_lp];

  typedef struct {
    logic [width_lp-1:0] din;
    logic                hold;
    logic [width_lp-1:0] e_data;
    logic [width_lp-1:0] e_rise;
    logic [width_lp-1:0] e_fall;
    logic                e_any;
  } vec_t;

  vec_t vecs[$];

  function automatic void modelReset();
    hist_q.delete();
    for (int k = 0; k < stages_lp; k++) hist_q.push_back({width_lp{reset_val_lp}});
    m_data = {width_lp{reset_val_lp}};
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < width_lp; b++) run_len[b] = 0;
  endfunction

  function automatic void modelEdge(input logic [width_lp-1:0] din, input logic hold);
    logic [width_lp-1:0] sy;
    sy     = hist_q[stages_lp-1];
    m_rise = '0;
    m_fall = '0;
    if (!hold) begin
      for (int b = 0; b < width_lp; b++) begin
        if (sy[b] == m_data[b]) begin
          run_len[b] = 0;
        end else begin
          run_len[b] = run_len[b] + 1;
          if (run_len[b] >= filter_lp) begin
            m_data[b]  = sy[b];
            m_rise[b]  = sy[b];
            m_fall[b]  = ~sy[b];
            run_len[b] = 0;
          end
        end
      end
    end
    hist_q.push_front(din);
    void'(hist_q.pop_back());
  endfunction

  function automatic void addVec(input logic [width_lp-1:0] din, input logic hold,
                                 input logic [width_lp-1:0] d, input logic [width_lp-1:0] r,
                                 input logic [width_lp-1:0] f, input logic a);
    vec_t v;
    v.din = din; v.hold = hold; v.e_data = d; v.e_rise = r; v.e_fall = f; v.e_any = a;
    vecs.push_back(v);
  endfunction

  task automatic checkOne(input string name, input logic [width_lp-1:0] act,
                          input logic [width_lp-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [width_lp-1:0] e_data,
                             input logic [width_lp-1:0] e_rise, input logic [width_lp-1:0] e_fall,
                             input logic e_any);
    checkOne({tag, ".data"}, bus.data_o, e_data);
    checkOne({tag, ".rise"}, bus.rise_o, e_rise);
    checkOne({tag, ".fall"}, bus.fall_o, e_fall);
    checkOne({tag, ".any"}, {{(width_lp-1){1'b0}}, bus.any_change_o},
             {{(width_lp-1){1'b0}}, e_any});
  endtask

  task automatic applyStimulus(input logic [width_lp-1:0] din, input logic hold);
    bus.async_data_i = din;
    bus.hold_i       = hold;
    @(posedge clk_i);
    #1;
    modelEdge(din, hold);
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [width_lp-1:0] rnd_din;
    logic                rnd_hold;
    int                  run;

    // Reset with raw inputs all high and no clock running.
    bus.async_data_i = 4'hF;
    bus.hold_i       = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    checkOutput("reset_noclk", 4'h0, 4'h0, 4'h0, 1'b0);
    clk_en = 1'b1;
    bus.async_data_i = 4'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    modelReset();

    // Latency, glitch rejection, simultaneous edges, hold stretch.
    for (int i = 0; i < 4; i++) addVec(4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    addVec(4'h1, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1);
    addVec(4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 2; i++) addVec(4'h3, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) addVec(4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) addVec(4'h8, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0);
    addVec(4'h8, 1'b0, 4'h8, 4'h8, 4'h1, 1'b1);
    for (int i = 0; i < 4; i++) addVec(4'h4, 1'b0, 4'h8, 4'h0, 4'h0, 1'b0);
    addVec(4'h4, 1'b0, 4'h4, 4'h4, 4'h8, 1'b1);
    addVec(4'h4, 1'b0, 4'h4, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) addVec(4'h5, 1'b0, 4'h4, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 2; i++) addVec(4'h5, 1'b1, 4'h4, 4'h0, 4'h0, 1'b0);
    addVec(4'h5, 1'b0, 4'h4, 4'h0, 4'h0, 1'b0);
    addVec(4'h5, 1'b0, 4'h5, 4'h1, 4'h0, 1'b1);
    addVec(4'h5, 1'b0, 4'h5, 4'h0, 4'h0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].din, vecs[i].hold);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_rise,
                  vecs[i].e_fall, vecs[i].e_any);
    end

    // Async reset between edges while the filter counters sit at their last value.
    for (int i = 0; i < 4; i++) applyStimulus(4'hA, 1'b0);
    checkOutput("midcount_pre", 4'h5, 4'h0, 4'h0, 1'b0);
    #3 reset_i = 1'b1;
    #1;
    checkOutput("midcount_reset", 4'h0, 4'h0, 4'h0, 1'b0);
    @(posedge clk_i);
    #1;
    checkOutput("reset_held", 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    modelReset();

    // Input differs from the reset value at release: normal pulse after full latency.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(4'hA, 1'b0);
      checkOutput($sformatf("post_reset%0d", i), (i >= 5) ? 4'hA : 4'h0,
                  (i == 5) ? 4'hA : 4'h0, 4'h0, (i == 5));
    end

    // Randomized levels held for short random runs, occasional hold, against the model.
    for (int i = 0; i < 150; i++) begin
      rnd_din = width_lp'($urandom);
      run     = int'($urandom_range(1, 5));
      for (int j = 0; j < run; j++) begin
        rnd_hold = ($urandom_range(0, 5) == 0);
        applyStimulus(rnd_din, rnd_hold);
        checkOutput("random", m_data, m_rise, m_fall, |(m_rise | m_fall));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
